// File: rtl/spi_key_responder_if.sv
// SPI pins plus key-code and received-byte handshakes of the keyboard SPI responder.
// The responder uses the slave modport; whatever drives the pins and keys uses master.
interface spi_key_responder_if;
  logic       i_SPI_Clk;
  logic       i_SPI_CS_n;
  logic       i_SPI_MOSI;
  logic       o_SPI_MISO;
  logic [7:0] i_Key_Byte;
  logic       i_Key_DV;
  logic       o_Key_Full;
  logic [7:0] o_RX_Byte;
  logic       o_RX_DV;
  logic       o_Overflow;

  modport slave (
    input  i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI, i_Key_Byte, i_Key_DV,
    output o_SPI_MISO, o_Key_Full, o_RX_Byte, o_RX_DV, o_Overflow
  );

  modport master (
    output i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI, i_Key_Byte, i_Key_DV,
    input  o_SPI_MISO, o_Key_Full, o_RX_Byte, o_RX_DV, o_Overflow
  );
endinterface

// File: rtl/spi_key_responder.sv
// Mode-0 SPI responder for the keyboard chip select: queued key codes go out on MISO,
// MOSI is deserialized into bytes. Oversamples the SPI pins in the board clock domain.
module spi_key_responder #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] IDLE_BYTE  = 8'h00
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  spi_key_responder_if.slave   bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  state_t        state_q;
  logic [2:0]    sclk_q, cs_q;
  logic [1:0]    mosi_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    tx_q, rx_sr_q, rx_byte_q;
  logic [2:0]    bit_cnt_q;
  logic          reload_q, rx_done_q, rx_dv_q, miso_q, ovf_q;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_quiet, in_shift;
  logic load_tx, shift_tx, shift_rx, fifo_empty, fifo_full, pop, push;
  logic [7:0] pop_byte;

  // CS_n synchronizer resets low so a select already asserted at reset release is not a fall.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.i_SPI_Clk};
      cs_q   <= {cs_q[1:0], bus.i_SPI_CS_n};
      mosi_q <= {mosi_q[0], bus.i_SPI_MOSI};
    end
  end

  assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall  = ~sclk_q[1] & sclk_q[2];
  assign cs_fall    = ~cs_q[1] & cs_q[2];
  assign cs_rise    = cs_q[1] & ~cs_q[2];
  assign cs_quiet   = ~cs_fall & ~cs_rise;
  assign in_shift   = cs_quiet & (state_q == ST_SHIFT);

  // A chip-select edge in the same cycle overrides any SCLK activity.
  assign load_tx    = cs_quiet & ((state_q == ST_LOAD) |
                                  ((state_q == ST_SHIFT) & sclk_fall & reload_q));
  assign shift_tx   = in_shift & sclk_fall & ~reload_q;
  assign shift_rx   = in_shift & sclk_rise;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = load_tx & ~fifo_empty;
  assign push       = bus.i_Key_DV & (~fifo_full | pop);
  assign pop_byte   = pop ? mem_q[rd_ptr_q] : IDLE_BYTE;

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (bus.i_Key_DV && !push) ovf_q <= 1'b1;
      else if (pop)              ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push)          mem_q[wr_ptr_q] <= bus.i_Key_Byte;
    if (load_tx)       tx_q <= pop_byte;
    else if (shift_tx) tx_q <= {tx_q[6:0], 1'b0};
    if (shift_rx)      rx_sr_q <= {rx_sr_q[6:0], mosi_q[1]};
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      reload_q  <= 1'b0;
      rx_done_q <= 1'b0;
      rx_dv_q   <= 1'b0;
      rx_byte_q <= 8'h00;
      miso_q    <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      rx_dv_q   <= rx_done_q;
      if (rx_done_q) rx_byte_q <= rx_sr_q;
      miso_q    <= (state_q == ST_SHIFT) ? tx_q[7] : 1'b0;
      if (cs_rise) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= 3'd0;
        reload_q  <= 1'b0;
      end else if (cs_fall) begin
        state_q   <= ST_LOAD;
        bit_cnt_q <= 3'd0;
        reload_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            state_q   <= ST_SHIFT;
            bit_cnt_q <= 3'd0;
          end
          ST_SHIFT: begin
            if (shift_rx) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              // Eighth bit completes the byte; the next SCLK fall reloads TX.
              if (bit_cnt_q == 3'd7) begin
                reload_q  <= 1'b1;
                rx_done_q <= 1'b1;
              end
            end else if (sclk_fall && reload_q) begin
              reload_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_SPI_MISO = miso_q;
  assign bus.o_Key_Full = fifo_full;
  assign bus.o_RX_Byte  = rx_byte_q;
  assign bus.o_RX_DV    = rx_dv_q;
  assign bus.o_Overflow = ovf_q;

endmodule

// File: tb/tb_spi_key_responder.sv
// Bench for spi_key_responder: directed scenarios plus randomized rounds, checked
// against a queue-based model of the key FIFO and the SPI byte exchange.
module tb_spi_key_responder;

  localparam int         HALF  = 8;
  localparam int         DEPTH = 8;
  localparam logic [7:0] IDLEB = 8'h00;

  logic clk, rst_n;
  int   vectors, miscompares;

  spi_key_responder_if bus();

  spi_key_responder #(.FIFO_DEPTH(DEPTH), .IDLE_BYTE(IDLEB)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] model_q[$];
  logic       model_ovf;
  logic [7:0] rx_got[$];
  logic [7:0] mo_arr[8];

  always @(negedge clk) if (bus.o_RX_DV === 1'b1) rx_got.push_back(bus.o_RX_Byte);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_pop();
    if (model_q.size() > 0) begin
      model_ovf = 1'b0;
      return model_q.pop_front();
    end
    return IDLEB;
  endfunction

  task automatic push_key(input logic [7:0] b);
    @(negedge clk);
    bus.i_Key_Byte = b;
    bus.i_Key_DV   = 1'b1;
    @(negedge clk);
    bus.i_Key_DV   = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_full"}, 32'(bus.o_Key_Full), 32'(model_q.size() == DEPTH));
    check({tag, "_ovf"},  32'(bus.o_Overflow), 32'(model_ovf));
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.i_SPI_MOSI = mo[i];
      repeat (HALF) @(negedge clk);
      mi[i] = bus.o_SPI_MISO;
      bus.i_SPI_Clk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.i_SPI_Clk = 1'b0;
    end
  endtask

  // Whole-byte transfer of n bytes from mo_arr; every byte ends with an SCLK fall,
  // which fetches the following byte from the queue even when it is the last one.
  task automatic do_xfer(input int n, input string tag);
    logic [7:0] got, exp;
    rx_got.delete();
    bus.i_SPI_CS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    exp = model_pop();
    for (int k = 0; k < n; k++) begin
      spi_bits(mo_arr[k], 8, got);
      check($sformatf("%s_miso%0d", tag, k), 32'(got), 32'(exp));
      exp = model_pop();
    end
    repeat (HALF) @(negedge clk);
    bus.i_SPI_CS_n = 1'b1;
    repeat (HALF) @(negedge clk);
    check({tag, "_rxcount"}, 32'(rx_got.size()), 32'(n));
    for (int k = 0; k < n && k < rx_got.size(); k++)
      check($sformatf("%s_rx%0d", tag, k), 32'(rx_got[k]), 32'(mo_arr[k]));
  endtask

  initial begin
    logic [7:0] got, head;
    int n;
    vectors = 0; miscompares = 0; model_ovf = 1'b0;
    bus.i_SPI_Clk = 1'b0; bus.i_SPI_CS_n = 1'b1; bus.i_SPI_MOSI = 1'b0;
    bus.i_Key_Byte = 8'h00; bus.i_Key_DV = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(bus.o_SPI_MISO), 0);
    check("rst_full", 32'(bus.o_Key_Full), 0);
    check("rst_rxbyte", 32'(bus.o_RX_Byte), 0);
    check("rst_rxdv", 32'(bus.o_RX_DV), 0);
    check("rst_ovf", 32'(bus.o_Overflow), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Empty FIFO: idle byte out, A5 in
    mo_arr[0] = 8'hA5;
    do_xfer(1, "t1");

    // Two queued keys across a three-byte transfer
    push_key(8'h1C); push_key(8'h32);
    mo_arr[0] = 8'h01; mo_arr[1] = 8'h02; mo_arr[2] = 8'h03;
    do_xfer(3, "t2");
    check_flags("t2");

    // Fill to full, drop the ninth push
    for (int i = 0; i < 9; i++) begin
      push_key(8'h10 + 8'(i));
      if (i >= 7) check_flags($sformatf("t3_push%0d", i));
    end
    mo_arr[0] = 8'h5A;
    do_xfer(1, "t3");
    check_flags("t3_after");

    // Refill to full, then push in the same cycle as the LOAD pop
    while (model_q.size() < DEPTH) push_key(8'h20 + 8'(model_q.size()));
    check_flags("t4_full");
    rx_got.delete();
    bus.i_SPI_CS_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_Key_Byte = 8'h99; bus.i_Key_DV = 1'b1;
    @(negedge clk);
    bus.i_Key_DV = 1'b0;
    head = model_pop();
    model_q.push_back(8'h99);
    check_flags("t4_coinc");
    repeat (HALF - 4) @(negedge clk);
    spi_bits(8'hC3, 8, got);
    check("t4_miso", 32'(got), 32'(head));
    void'(model_pop());
    repeat (HALF) @(negedge clk);
    bus.i_SPI_CS_n = 1'b1;
    repeat (HALF) @(negedge clk);
    check("t4_rxcount", 32'(rx_got.size()), 1);
    check_flags("t4_after");
    n = 0;
    while (model_q.size() > 0 && n < 10) begin
      mo_arr[0] = 8'(n); mo_arr[1] = 8'(n + 1); mo_arr[2] = 8'(n + 2);
      do_xfer(3, $sformatf("t4_drain%0d", n));
      n++;
    end

    // Abort mid-byte after 5 rises
    push_key(8'h44); push_key(8'h55);
    rx_got.delete();
    bus.i_SPI_CS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    head = model_pop();
    spi_bits(8'hF0, 5, got);
    check("t5_partial", 32'(got[7:3]), 32'(head[7:3]));
    repeat (HALF) @(negedge clk);
    bus.i_SPI_CS_n = 1'b1;
    repeat (HALF) @(negedge clk);
    check("t5_nodv", 32'(rx_got.size()), 0);
    mo_arr[0] = 8'h81;
    do_xfer(1, "t5_next");

    // Reset after 3 bits, CS_n held low across release
    push_key(8'h66); push_key(8'h77);
    bus.i_SPI_CS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'hE7, 3, got);
    rst_n = 1'b0;
    #1;
    check("t6_miso", 32'(bus.o_SPI_MISO), 0);
    check("t6_full", 32'(bus.o_Key_Full), 0);
    check("t6_ovf", 32'(bus.o_Overflow), 0);
    model_q.delete(); model_ovf = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rx_got.delete();
    spi_bits(8'hFF, 8, got);
    repeat (HALF) @(negedge clk);
    check("t6_held_miso", 32'(got), 0);
    check("t6_held_nodv", 32'(rx_got.size()), 0);
    bus.i_SPI_CS_n = 1'b1;
    repeat (HALF) @(negedge clk);
    mo_arr[0] = 8'h3C;
    do_xfer(1, "t6_fresh");

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) push_key(8'($urandom));
      check_flags($sformatf("r%0d_pushed", r));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) mo_arr[k] = 8'($urandom);
      do_xfer(n, $sformatf("r%0d", r));
      check_flags($sformatf("r%0d_after", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
